// File: rtl/axi_cmd_responder_if.sv
// Host command encodings plus the bundle of host-register, BRAM and regex-core signals
// seen by axi_cmd_responder (slave) and its surroundings (master).
package AXI_package;
    localparam logic [7:0] CMD_NOP                = 8'd0;
    localparam logic [7:0] CMD_WRITE              = 8'd1;
    localparam logic [7:0] CMD_READ               = 8'd2;
    localparam logic [7:0] CMD_START              = 8'd3;
    localparam logic [7:0] CMD_READ_ELAPSED_CLOCK = 8'd5;

    localparam logic [7:0] STATUS_IDLE     = 8'd0;
    localparam logic [7:0] STATUS_RUNNING  = 8'd1;
    localparam logic [7:0] STATUS_ACCEPTED = 8'd2;
    localparam logic [7:0] STATUS_REJECTED = 8'd3;
    localparam logic [7:0] STATUS_ERROR    = 8'd4;
endpackage

interface axi_cmd_responder_if #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 12
);
    logic [REG_WIDTH-1:0]      cmd_register;
    logic [REG_WIDTH-1:0]      address_register;
    logic [REG_WIDTH-1:0]      data_in_register;
    logic [REG_WIDTH-1:0]      start_cc_pointer_register;
    logic [REG_WIDTH-1:0]      end_cc_pointer_register;
    logic [REG_WIDTH-1:0]      status_register;
    logic [REG_WIDTH-1:0]      data_o_register;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]      mem_wdata;
    logic [REG_WIDTH-1:0]      mem_rdata;
    logic                      core_start;
    logic [REG_WIDTH-1:0]      core_start_cc_pointer;
    logic [REG_WIDTH-1:0]      core_end_cc_pointer;
    logic                      core_done;
    logic                      core_accept;

    modport slave (
        input  cmd_register, address_register, data_in_register,
        input  start_cc_pointer_register, end_cc_pointer_register,
        input  mem_rdata, core_done, core_accept,
        output status_register, data_o_register,
        output mem_we, mem_addr, mem_wdata,
        output core_start, core_start_cc_pointer, core_end_cc_pointer
    );

    modport master (
        output cmd_register, address_register, data_in_register,
        output start_cc_pointer_register, end_cc_pointer_register,
        output mem_rdata, core_done, core_accept,
        input  status_register, data_o_register,
        input  mem_we, mem_addr, mem_wdata,
        input  core_start, core_start_cc_pointer, core_end_cc_pointer
    );
endinterface

// File: rtl/axi_cmd_responder.sv
// Host command responder for the CICERO core: BRAM word access, core launch, status FSM
// and elapsed-clock counter. Define CICERO_ACCESS_GUARD_EN to block writes/starts while running.
module axi_cmd_responder
    import AXI_package::*;
#(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter int unsigned CC_ID_BITS     = 32
) (
    input  logic               clk,
    input  logic               rst,
    axi_cmd_responder_if.slave bus
);

`ifdef CICERO_ACCESS_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // State values double as the STATUS_* codes driven on status_register.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUNNING  = 3'd1,
        S_DONE_ACC = 3'd2,
        S_DONE_REJ = 3'd3,
        S_DONE_ERR = 3'd4
    } state_t;

    state_t state, state_d;

    logic [REG_WIDTH-1:0]      cmd_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0]      data_q;
    logic                      start_q;
    logic                      rd_pend;
    logic                      err_q;
    logic [CC_ID_BITS-1:0]     counter;

    logic cmd_is_write, cmd_is_read, cmd_is_start, cmd_is_elapsed;
    logic running, start_edge, launch, violation, wr_ok, rd_ok;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.address_register[REG_WIDTH-1:MEM_ADDR_WIDTH];

    assign cmd_is_write   = (cmd_q == REG_WIDTH'(CMD_WRITE));
    assign cmd_is_read    = (cmd_q == REG_WIDTH'(CMD_READ));
    assign cmd_is_start   = (cmd_q == REG_WIDTH'(CMD_START));
    assign cmd_is_elapsed = (cmd_q == REG_WIDTH'(CMD_READ_ELAPSED_CLOCK));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_RUNNING: begin
                if (bus.core_done) begin
                    if (GUARD && (err_q || violation)) state_d = S_DONE_ERR;
                    else if (bus.core_accept)          state_d = S_DONE_ACC;
                    else                               state_d = S_DONE_REJ;
                end
            end
            default: begin
                if (start_edge) state_d = S_RUNNING;
            end
        endcase
    end

    // Memory port is driven straight from the registered command so a read reaches
    // data_o three edges after the host changes cmd/address; rst blanks it at once.
    always_comb begin
        running    = (state == S_RUNNING);
        start_edge = cmd_is_start && !start_q;
        launch     = !running && start_edge;
        violation  = running && (cmd_is_write || start_edge);
        wr_ok      = cmd_is_write && (!running || !GUARD);
        rd_ok      = cmd_is_read && !running;

        bus.status_register = REG_WIDTH'(state);
        bus.mem_we          = wr_ok && !rst;
        bus.mem_addr        = rst ? '0 : addr_q;
        bus.mem_wdata       = rst ? '0 : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q                     <= '0;
            addr_q                    <= '0;
            data_q                    <= '0;
            start_q                   <= 1'b0;
            rd_pend                   <= 1'b0;
            err_q                     <= 1'b0;
            counter                   <= '0;
            bus.data_o_register       <= '0;
            bus.core_start            <= 1'b0;
            bus.core_start_cc_pointer <= '0;
            bus.core_end_cc_pointer   <= '0;
        end else begin
            cmd_q          <= bus.cmd_register;
            addr_q         <= bus.address_register[MEM_ADDR_WIDTH-1:0];
            data_q         <= bus.data_in_register;
            start_q        <= cmd_is_start;
            rd_pend        <= rd_ok;
            bus.core_start <= launch;

            if (launch) begin
                bus.core_start_cc_pointer <= bus.start_cc_pointer_register;
                bus.core_end_cc_pointer   <= bus.end_cc_pointer_register;
                counter                   <= '0;
            end else if (running && (counter != '1)) begin
                counter <= counter + CC_ID_BITS'(1);
            end

            if (launch)                  err_q <= 1'b0;
            else if (GUARD && violation) err_q <= 1'b1;

            // A pending BRAM read completes before any elapsed-clock request.
            if (rd_pend)             bus.data_o_register <= bus.mem_rdata;
            else if (cmd_is_elapsed) bus.data_o_register <= REG_WIDTH'(counter);
        end
    end

endmodule

// File: doc/axi_cmd_responder.md
Name: axi_cmd_responder

Overview:
- Responder side of the host register/command interface that drives the CICERO core.
- Samples the host-held command, address and data registers, then:
  - streams word writes and reads into the shared code/string BRAM,
  - launches the regex core with start/end character pointers,
  - runs the status state machine,
  - counts elapsed clock cycles per run.
- Sits between the host register file and the regex core plus its memory port.

Parameters:
REG_WIDTH, 32, width of every host register and of the memory data word
MEM_ADDR_WIDTH, 12, word-address width of the BRAM port (upper address_register bits ignored)
CC_ID_BITS, 32, width of the elapsed-clock counter; must be <= REG_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_register  in  REG_WIDTH  host command, level-held (CMD_* encodings from AXI_package)
address_register  in  REG_WIDTH  host word address for CMD_WRITE / CMD_READ
data_in_register  in  REG_WIDTH  host write data
start_cc_pointer_register  in  REG_WIDTH  byte address of first string character
end_cc_pointer_register  in  REG_WIDTH  byte address of last string character (inclusive)
status_register  out  REG_WIDTH  STATUS_IDLE / RUNNING / ACCEPTED / REJECTED / ERROR
data_o_register  out  REG_WIDTH  read data or elapsed-clock value
mem_we  out  1  BRAM write enable
mem_addr  out  MEM_ADDR_WIDTH  BRAM word address
mem_wdata  out  REG_WIDTH  BRAM write data
mem_rdata  in  REG_WIDTH  BRAM read data, valid one cycle after mem_addr
core_start  out  1  one-cycle start pulse to the regex core
core_start_cc_pointer  out  REG_WIDTH  start pointer latched at launch
core_end_cc_pointer  out  REG_WIDTH  end pointer latched at launch
core_done  in  1  one-cycle pulse: core finished
core_accept  in  1  result qualifier, valid with core_done

Behaviour:
- Reset values: status = STATUS_IDLE, data_o = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, core_start = 0, both core pointers = 0, counter = 0.
- Inputs are registered once (cmd_q, addr_q, data_q); all decode acts on the registered copies.
- FSM states: IDLE, RUNNING, DONE_ACC, DONE_REJ. status_register is a direct encoding of the state.
- CMD_WRITE, valid in IDLE or DONE_*, per cycle:
  - mem_we = 1, mem_addr = addr_q[MEM_ADDR_WIDTH-1:0], mem_wdata = data_q.
  - Address and data changes while the command is held stream as successive writes, one write per cycle.
- CMD_READ, valid in IDLE or DONE_*, per cycle:
  - mem_addr = addr_q.
  - data_o <= mem_rdata one cycle later.
  - Total latency from cmd_register/address change to data_o = 3 cycles.
  - data_o holds its last value after the command returns to CMD_NOP.
- CMD_START from IDLE or DONE_*:
  - latch both pointers, pulse core_start for 1 cycle, clear counter, enter RUNNING.
  - status reads STATUS_RUNNING no later than 2 cycles after cmd_register = CMD_START.
  - A held CMD_START re-launches only after the next rising edge of the command (edge-detected on cmd_q).
- RUNNING:
  - counter increments every cycle and saturates at all-ones.
  - core_done moves to DONE_ACC if core_accept = 1, else DONE_REJ; the counter freezes.
  - core_done and CMD_START in the same cycle: done wins; the new start needs a fresh edge.
- CMD_READ_ELAPSED_CLOCK: data_o <= zero-extended counter, 1-cycle latency; legal in any state.
- CMD_NOP and unknown encodings: no action, data_o held.
- rst mid-run: FSM returns to IDLE next cycle, core_start forced to 0, and any in-flight write is dropped (mem_we = 0).

Optional Feature:
- Macro: CICERO_ACCESS_GUARD_EN.
- Defined: CMD_WRITE or CMD_START issued while RUNNING is suppressed (no mem_we, no relaunch), and status becomes STATUS_ERROR once the run ends, instead of ACCEPTED/REJECTED. STATUS_ERROR is cleared only by rst or by a new CMD_START.
- Undefined: writes while RUNNING pass through to the BRAM, CMD_START while RUNNING is ignored, and STATUS_ERROR is never produced.

Test Plan:
- Streamed write: hold CMD_WRITE while stepping address 0,1,2 with data 0x11112222/0x33334444/0x55556666, then CMD_READ on address 1 -> data_o = 0x33334444 three cycles after the address is applied, held after CMD_NOP.
- Accept run: pointers 0x40/0x4F, CMD_START, core_done+core_accept 20 cycles later -> RUNNING within 2 cycles, then STATUS_ACCEPTED, CMD_READ_ELAPSED_CLOCK returns 20 (±1 per the defined launch edge).
- Reject run: core_done with core_accept = 0 -> STATUS_REJECTED; core_start_cc_pointer = 0x40 and core_end_cc_pointer = 0x4F held throughout.
- Held CMD_START for 10 cycles after done -> exactly one core_start pulse in total.
- rst asserted during RUNNING with counter = 7 -> status IDLE, core outputs 0, counter 0 next cycle.
- With CICERO_ACCESS_GUARD_EN: CMD_WRITE while RUNNING -> mem_we stays 0; after core_done, status = STATUS_ERROR. Without the macro: mem_we = 1 and status = ACCEPTED/REJECTED.
